// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divisor, tick pulse and square wave.
// Optional macro CLKGEN_FREERUN_EN adds a 32-bit free-running cycle counter on divided_clocks.
module clock_enable_gen #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 26,
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [IDX_W-1:0]    load_ch,
  input  logic [WIDTH-1:0]    load_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] square,
  output logic [CHANNELS-1:0] active
`ifdef CLKGEN_FREERUN_EN
  ,
  output logic [31:0]         divided_clocks
`endif
);

  logic [WIDTH-1:0] div [CHANNELS];
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic             load_ok;

  // Indices past the last channel are only reachable when CHANNELS is not a power of two.
  assign load_ok = load && (32'(load_ch) < 32'(CHANNELS));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        div[c] <= '0;
        cnt[c] <= '0;
      end
      tick   <= '0;
      square <= '0;
      active <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (load_ok && (load_ch == IDX_W'(c))) begin
          div[c]    <= load_div;
          cnt[c]    <= '0;
          tick[c]   <= 1'b0;
          square[c] <= 1'b0;
          active[c] <= (load_div != '0);
        end else if (div[c] == '0) begin
          cnt[c]    <= '0;
          tick[c]   <= 1'b0;
          square[c] <= 1'b0;
        end else if (!enable) begin
          tick[c]   <= 1'b0;
        end else if (cnt[c] == div[c] - WIDTH'(1)) begin
          // div is nonzero here, so div-1 never underflows and the full range is usable.
          cnt[c]    <= '0;
          tick[c]   <= 1'b1;
          square[c] <= ~square[c];
        end else begin
          cnt[c]    <= cnt[c] + WIDTH'(1);
          tick[c]   <= 1'b0;
        end
      end
    end
  end

`ifdef CLKGEN_FREERUN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      divided_clocks <= '0;
    end else begin
      divided_clocks <= divided_clocks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: hand-computed checks plus a per-cycle arithmetic reference.
// A second instance (CHANNELS=6, WIDTH=4) covers the out-of-range index and maximum divisor.
module tb_clock_enable_gen;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        load;
  logic [1:0]  load_ch;
  logic [25:0] load_div;
  logic [3:0]  tick;
  logic [3:0]  square;
  logic [3:0]  active;

  logic        b_load;
  logic [2:0]  b_ch;
  logic [3:0]  b_div;
  logic [5:0]  b_tick;
  logic [5:0]  b_square;
  logic [5:0]  b_active;

`ifdef CLKGEN_FREERUN_EN
  logic [31:0] divided_clocks;
  logic [31:0] b_fr;
`endif

  int nchk = 0;
  int errs = 0;

  int md [4];
  int mn [4];
  bit mt [4];

  clock_enable_gen #(.CHANNELS(4), .WIDTH(26)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_ch(load_ch), .load_div(load_div),
    .tick(tick), .square(square), .active(active)
`ifdef CLKGEN_FREERUN_EN
    , .divided_clocks(divided_clocks)
`endif
  );

  clock_enable_gen #(.CHANNELS(6), .WIDTH(4)) u_big (
    .clock(clock), .reset(reset), .enable(enable), .load(b_load),
    .load_ch(b_ch), .load_div(b_div),
    .tick(b_tick), .square(b_square), .active(b_active)
`ifdef CLKGEN_FREERUN_EN
    , .divided_clocks(b_fr)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the reference from the inputs sampled at that edge, then compare.
  task automatic cyc();
    logic        r, e, l;
    logic [1:0]  lc;
    logic [25:0] ld;
    logic [3:0]  et, es, ea;
    r = reset; e = enable; l = load; lc = load_ch; ld = load_div;
    @(posedge clock);
    for (int c = 0; c < 4; c++) begin
      if (r) begin
        md[c] = 0; mn[c] = 0; mt[c] = 1'b0;
      end else if (l && (int'(lc) == c)) begin
        md[c] = int'(ld); mn[c] = 0; mt[c] = 1'b0;
      end else if (md[c] == 0) begin
        mt[c] = 1'b0;
      end else if (e) begin
        mn[c]++;
        mt[c] = ((mn[c] % md[c]) == 0);
      end else begin
        mt[c] = 1'b0;
      end
    end
    #1;
    for (int c = 0; c < 4; c++) begin
      et[c] = mt[c];
      es[c] = (md[c] == 0) ? 1'b0 : (((mn[c] / md[c]) % 2) == 1);
      ea[c] = (md[c] != 0);
    end
    chk("ref_tick",   32'(tick),   32'(et));
    chk("ref_square", 32'(square), 32'(es));
    chk("ref_active", 32'(active), 32'(ea));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
    b_load = 1'b0; b_ch = '0; b_div = '0;
    for (int c = 0; c < 4; c++) begin md[c] = 0; mn[c] = 0; mt[c] = 1'b0; end
    cyc(); cyc();
    chk("rst_tick",     32'(tick),     0);
    chk("rst_square",   32'(square),   0);
    chk("rst_active",   32'(active),   0);
    chk("rst_b_active", 32'(b_active), 0);
    reset = 1'b0;
    cyc();
    chk("idle_tick",   32'(tick),   0);
    chk("idle_active", 32'(active), 0);

    // ch0 D=4
    load = 1'b1; load_ch = 2'd0; load_div = 26'd4; enable = 1'b1;
    cyc();
    load = 1'b0;
    chk("d4_active", 32'(active), 32'h1);
    chk("d4_tick0",  32'(tick),   0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("d4_tick",   32'(tick[0]),   32'((k % 4) == 0));
      chk("d4_square", 32'(square[0]), 32'(((k / 4) % 2) == 1));
    end

    // ch1 D=1 at k=13, ch2 D=3 at k=14
    load = 1'b1; load_ch = 2'd1; load_div = 26'd1;
    cyc();
    chk("ch1_load_tick", 32'(tick), 0);
    load_ch = 2'd2; load_div = 26'd3;
    cyc();
    load = 1'b0;
    chk("ch12_active", 32'(active), 32'h7);
    chk("ch1_first",   32'(tick),   32'h2);
    for (int k = 15; k <= 26; k++) begin
      cyc();
      chk("multi_tick", 32'(tick),
          32'({1'b0, ((k - 14) % 3) == 0, 1'b1, (k % 4) == 0}));
    end

    // ch0 D=5 with a 7-cycle enable gap after two counts
    load = 1'b1; load_ch = 2'd0; load_div = 26'd5;
    cyc();
    load = 1'b0;
    cyc(); cyc();
    enable = 1'b0;
    for (int g = 0; g < 7; g++) begin
      cyc();
      chk("gap_tick",   32'(tick),   0);
      chk("gap_square", 32'(square), 32'h4);
    end
    enable = 1'b1;
    cyc();
    chk("resume_n3", 32'(tick[0]), 0);
    cyc();
    chk("resume_n4", 32'(tick[0]), 0);
    cyc();
    chk("resume_tick",   32'(tick[0]),   1);
    chk("resume_square", 32'(square[0]), 1);

    // reload ch0 with D=2 exactly on its next wrap
    repeat (4) cyc();
    load = 1'b1; load_ch = 2'd0; load_div = 26'd2;
    cyc();
    load = 1'b0;
    chk("reload_tick",   32'(tick[0]),   0);
    chk("reload_square", 32'(square[0]), 0);
    cyc();
    chk("reload_n1", 32'(tick[0]), 0);
    cyc();
    chk("reload_first",  32'(tick[0]),   1);
    chk("reload_sq",     32'(square[0]), 1);
    load = 1'b1; load_ch = 2'd0; load_div = 26'd0;
    cyc();
    load = 1'b0;
    chk("stop_active", 32'(active), 32'h6);
    for (int s = 0; s < 4; s++) begin
      cyc();
      chk("stop_tick",   32'(tick[0]),   0);
      chk("stop_square", 32'(square[0]), 0);
    end

    // reset wins over a simultaneous load
    reset = 1'b1; load = 1'b1; load_ch = 2'd0; load_div = 26'd6;
    cyc();
    chk("rl_tick",   32'(tick),   0);
    chk("rl_square", 32'(square), 0);
    chk("rl_active", 32'(active), 0);
    reset = 1'b0; load = 1'b0;
    for (int s = 0; s < 8; s++) begin
      cyc();
      chk("post_rst_tick",   32'(tick),   0);
      chk("post_rst_active", 32'(active), 0);
    end

    // 6-channel instance: max divisor on ch5, then an out-of-range write
    b_load = 1'b1; b_ch = 3'd5; b_div = 4'd15;
    cyc();
    b_ch = 3'd7; b_div = 4'd3;
    cyc();
    b_load = 1'b0;
    chk("oor_active", 32'(b_active), 32'h20);
    chk("oor_tick",   32'(b_tick),   0);
    repeat (13) cyc();
    chk("dmax_n14", 32'(b_tick), 0);
    cyc();
    chk("dmax_tick",   32'(b_tick),   32'h20);
    chk("dmax_square", 32'(b_square), 32'h20);
    chk("dmax_active", 32'(b_active), 32'h20);

`ifdef CLKGEN_FREERUN_EN
    reset = 1'b1;
    cyc();
    chk("fr_reset", divided_clocks, 0);
    reset = 1'b0; enable = 1'b0;
    repeat (100) cyc();
    chk("fr_100",   divided_clocks, 100);
    chk("fr_b_100", b_fr,           100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, errs);
    $finish;
  end

endmodule
